// File: rtl/ram_pkg.sv
// Shared types and default sizes for the synchronous RAM slice.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_t;

  localparam int RAM_DATA_W = 2;
  localparam int RAM_ADDR_W = 2;

endpackage

// File: rtl/ram_clear_fsm.sv
// Post-reset clear sequencer: sweeps every address once, then raises ready.
module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ready_q, ready_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end

  // Pointer wraps to 0 on the last clear write; it is unused once READY.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = ~rst;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == '1) begin
          state_d = READY;
          ready_d = 1'b1;
        end
      end
      READY: ;
      default: state_d = CLEAR;
    endcase
  end

  assign clr_addr = ptr_q;
  assign ready    = ready_q;

endmodule

// File: rtl/ram_sync.sv
// One-write/one-read synchronous RAM with registered read, read-first on
// address collision, and a clear sweep after every reset.
module ram_sync
  import ram_pkg::*;
#(
  parameter int                DATA_W    = RAM_DATA_W,
  parameter int                ADDR_W    = RAM_ADDR_W,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_acc;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  ram_clear_fsm #(.ADDR_W(ADDR_W)) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  // clr_we and ready are mutually exclusive, so the sweep simply owns the port.
  always_comb begin
    wr_en   = clr_we | (ready & we & ~rst);
    wr_addr = clr_we ? clr_addr : waddr;
    wr_data = clr_we ? CLEAR_VAL : wdata;
    rd_acc  = ready & re & ~rst;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Nonblocking update of mem makes same-address read-during-write read-first.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) rdata_q <= mem[raddr];
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule
